// File: rtl/exe_muldiv_unit_if.sv
// ============================================================================
// Module   : exe_muldiv_unit_if
// Brief    : Issue/result handshake bundle between execute stage and MDU.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface exe_muldiv_unit_if #(
  parameter int DATA_W = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        in_op;
  logic [DATA_W-1:0] in_src1;
  logic [DATA_W-1:0] in_src2;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_result;

  modport master (
    output in_valid, in_op, in_src1, in_src2, out_ready,
    input  in_ready, out_valid, out_result
  );

  modport slave (
    input  in_valid, in_op, in_src1, in_src2, out_ready,
    output in_ready, out_valid, out_result
  );
endinterface

`default_nettype wire

// File: rtl/exe_muldiv_unit.sv
// ============================================================================
// Module   : exe_muldiv_unit
// Brief    : Multi-cycle MUL/DIV unit owning HI/LO; MDU_RADIX4_DIV_EN selects
//            a 2-bit-per-cycle divider.
// Revision : 1.0
// ============================================================================
`default_nettype none

module exe_muldiv_unit #(
  parameter int DATA_W     = 32,
  parameter int MUL_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  exe_muldiv_unit_if.slave      bus,
  input  logic                  flush,
  output logic                  busy,
  output logic [DATA_W-1:0]     hi,
  output logic [DATA_W-1:0]     lo
);

  localparam int CNT_W = $clog2(DATA_W);
`ifdef MDU_RADIX4_DIV_EN
  localparam int DIV_STEP = 2;
`else
  localparam int DIV_STEP = 1;
`endif
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - DIV_STEP);
  localparam logic [CNT_W-1:0] CNT_INC  = CNT_W'(DIV_STEP);
  localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'((MUL_STAGES >= 2) ? (MUL_STAGES - 2) : 0);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;
  localparam logic [2:0] OP_MFHI  = 3'd6;
  localparam logic [2:0] OP_MFLO  = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] quo_q, quo_d, rem_q, rem_d, dvsr_q, dvsr_d;
  logic              qneg_q, qneg_d, rneg_q, rneg_d;
  logic [DATA_W-1:0] res_hi_q, res_hi_d, res_lo_q, res_lo_d;
  logic              wr_hi_q, wr_hi_d, wr_lo_q, wr_lo_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_result_q, out_result_d;
  logic [DATA_W-1:0] hi_q, hi_d, lo_q, lo_d;

  logic                in_ready, accept, commit;
  logic                signed_op, a_neg, b_neg;
  logic [DATA_W-1:0]   a_mag, b_mag;
  logic [2*DATA_W-1:0] prod_mag, prod;
  logic [2*DATA_W-1:0] step1, div_next;
  logic [DATA_W-1:0]   q_raw, r_raw;

  // One restoring step: returns {remainder, quotient-shift-register}.
  function automatic logic [2*DATA_W-1:0] div_step(
    input logic [DATA_W-1:0] rem,
    input logic [DATA_W-1:0] quo,
    input logic [DATA_W-1:0] d
  );
    logic [DATA_W:0] sh;
    logic [DATA_W:0] diff;
    sh   = {rem, quo[DATA_W-1]};
    diff = sh - {1'b0, d};
    if (sh >= {1'b0, d}) return {diff[DATA_W-1:0], quo[DATA_W-2:0], 1'b1};
    else                 return {sh[DATA_W-1:0],   quo[DATA_W-2:0], 1'b0};
  endfunction

  assign in_ready  = (state_q == S_IDLE) || ((state_q == S_DONE) && bus.out_ready);
  assign accept    = bus.in_valid && in_ready && !flush;
  assign commit    = (state_q == S_DONE) && bus.out_ready && !flush;

  assign signed_op = (bus.in_op == OP_MULT) || (bus.in_op == OP_DIV);
  assign a_neg     = signed_op && bus.in_src1[DATA_W-1];
  assign b_neg     = signed_op && bus.in_src2[DATA_W-1];
  assign a_mag     = a_neg ? -bus.in_src1 : bus.in_src1;
  assign b_mag     = b_neg ? -bus.in_src2 : bus.in_src2;
  assign prod_mag  = {{DATA_W{1'b0}}, a_mag} * {{DATA_W{1'b0}}, b_mag};
  assign prod      = (a_neg ^ b_neg) ? -prod_mag : prod_mag;

  assign step1 = div_step(rem_q, quo_q, dvsr_q);
`ifdef MDU_RADIX4_DIV_EN
  assign div_next = div_step(step1[2*DATA_W-1:DATA_W], step1[DATA_W-1:0], dvsr_q);
`else
  assign div_next = step1;
`endif
  assign r_raw = div_next[2*DATA_W-1:DATA_W];
  assign q_raw = div_next[DATA_W-1:0];

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    quo_d        = quo_q;
    rem_d        = rem_q;
    dvsr_d       = dvsr_q;
    qneg_d       = qneg_q;
    rneg_d       = rneg_q;
    res_hi_d     = res_hi_q;
    res_lo_d     = res_lo_q;
    wr_hi_d      = wr_hi_q;
    wr_lo_d      = wr_lo_q;
    out_result_d = out_result_q;
    hi_d         = hi_q;
    lo_d         = lo_q;

    if (commit) begin
      if (wr_hi_q) hi_d = res_hi_q;
      if (wr_lo_q) lo_d = res_lo_q;
      state_d      = S_IDLE;
      out_result_d = '0;
    end

    case (state_q)
      S_MUL: begin
        if (cnt_q == MUL_LAST) state_d = S_DONE;
        else                   cnt_d   = cnt_q + CNT_W'(1);
      end
      S_DIV: begin
        rem_d = r_raw;
        quo_d = q_raw;
        cnt_d = cnt_q + CNT_INC;
        if (cnt_q == CNT_LAST) begin
          state_d  = S_DONE;
          res_lo_d = qneg_q ? -q_raw : q_raw;
          res_hi_d = rneg_q ? -r_raw : r_raw;
        end
      end
      default: ;
    endcase

    // hi_d/lo_d already hold any same-cycle commit, so MFHI/MFLO see it.
    if (accept) begin
      cnt_d        = '0;
      wr_hi_d      = 1'b0;
      wr_lo_d      = 1'b0;
      out_result_d = '0;
      state_d      = S_DONE;
      case (bus.in_op)
        OP_MULT, OP_MULTU: begin
          {res_hi_d, res_lo_d} = prod;
          wr_hi_d = 1'b1;
          wr_lo_d = 1'b1;
          state_d = (MUL_STAGES == 1) ? S_DONE : S_MUL;
        end
        OP_DIV, OP_DIVU: begin
          quo_d   = a_mag;
          rem_d   = '0;
          dvsr_d  = b_mag;
          // Divide-by-zero keeps the all-ones quotient unsigned-looking.
          qneg_d  = (a_neg ^ b_neg) && (bus.in_src2 != '0);
          rneg_d  = a_neg;
          wr_hi_d = 1'b1;
          wr_lo_d = 1'b1;
          state_d = S_DIV;
        end
        OP_MTHI: begin res_hi_d = bus.in_src1; wr_hi_d = 1'b1; end
        OP_MTLO: begin res_lo_d = bus.in_src1; wr_lo_d = 1'b1; end
        OP_MFHI: out_result_d = hi_d;
        OP_MFLO: out_result_d = lo_d;
        default: ;
      endcase
    end

    if (flush) begin
      state_d      = S_IDLE;
      out_result_d = '0;
    end

    out_valid_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      quo_q        <= '0;
      rem_q        <= '0;
      dvsr_q       <= '0;
      qneg_q       <= 1'b0;
      rneg_q       <= 1'b0;
      res_hi_q     <= '0;
      res_lo_q     <= '0;
      wr_hi_q      <= 1'b0;
      wr_lo_q      <= 1'b0;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      hi_q         <= '0;
      lo_q         <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      quo_q        <= quo_d;
      rem_q        <= rem_d;
      dvsr_q       <= dvsr_d;
      qneg_q       <= qneg_d;
      rneg_q       <= rneg_d;
      res_hi_q     <= res_hi_d;
      res_lo_q     <= res_lo_d;
      wr_hi_q      <= wr_hi_d;
      wr_lo_q      <= wr_lo_d;
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
      hi_q         <= hi_d;
      lo_q         <= lo_d;
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_result = out_result_q;
  assign busy           = (state_q != S_IDLE);
  assign hi             = hi_q;
  assign lo             = lo_q;

endmodule

`default_nettype wire

// File: tb/tb_exe_muldiv_unit.sv
// ============================================================================
// Module   : tb_exe_muldiv_unit
// Brief    : Directed scoreboard bench for exe_muldiv_unit (DATA_W=32).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_exe_muldiv_unit;

`ifdef MDU_RADIX4_DIV_EN
  localparam int DIV_LAT = 17;
`else
  localparam int DIV_LAT = 33;
`endif
  localparam int MUL_LAT = 2;

  typedef struct packed {
    logic [31:0] res;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  exe_muldiv_unit_if #(.DATA_W(32)) bus ();

  exe_muldiv_unit #(.DATA_W(32), .MUL_STAGES(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .flush (flush),
    .busy  (busy),
    .hi    (hi),
    .lo    (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_pass   = 0;
  exp_t sb[$];
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Reference model: 64-bit arithmetic, independent of the datapath.
  function automatic exp_t model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb_v, p, q, r;
    logic [63:0] ua, ub, pu, qu, ru;
    logic [31:0] res;
    sa = longint'($signed(a));
    sb_v = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    res = '0;
    case (op)
      3'd0: begin p = sa * sb_v; m_hi = p[63:32]; m_lo = p[31:0]; end
      3'd1: begin pu = ua * ub; m_hi = pu[63:32]; m_lo = pu[31:0]; end
      3'd2: begin
        if (b == 0) begin m_lo = 32'hFFFF_FFFF; m_hi = a; end
        else begin q = sa / sb_v; r = sa % sb_v; m_lo = q[31:0]; m_hi = r[31:0]; end
      end
      3'd3: begin
        if (b == 0) begin m_lo = 32'hFFFF_FFFF; m_hi = a; end
        else begin qu = ua / ub; ru = ua % ub; m_lo = qu[31:0]; m_hi = ru[31:0]; end
      end
      3'd4: m_hi = a;
      3'd5: m_lo = a;
      3'd6: res = m_hi;
      default: res = m_lo;
    endcase
    return '{res: res, hi: m_hi, lo: m_lo};
  endfunction

  task automatic do_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input int exp_lat);
    exp_t e;
    int   lat;
    bit   seen;
    sb.push_back(model(op, a, b));
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_op = op; bus.in_src1 = a; bus.in_src2 = b; bus.out_ready = 1'b1;
    check({tag, " in_ready"}, 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    lat = 0; seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      lat++;
      seen = bus.out_valid;
    end
    check({tag, " latency"}, 64'(lat), 64'(exp_lat));
    e = sb.pop_front();
    check({tag, " result"}, 64'(bus.out_result), 64'(e.res));
    @(negedge clk);
    check({tag, " hi"}, 64'(hi), 64'(e.hi));
    check({tag, " lo"}, 64'(lo), 64'(e.lo));
    check({tag, " valid_drop"}, 64'(bus.out_valid), 64'd0);
  endtask

  initial begin
    exp_t e;
    bit   any_valid;
    logic [31:0] held;

    reset = 1'b1; flush = 1'b0;
    bus.in_valid = 1'b0; bus.in_op = '0; bus.in_src1 = '0; bus.in_src2 = '0; bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst out_valid", 64'(bus.out_valid), 64'd0);
    check("rst out_result", 64'(bus.out_result), 64'd0);
    check("rst busy", 64'(busy), 64'd0);
    check("rst hi", 64'(hi), 64'd0);
    check("rst lo", 64'(lo), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    check("rst in_ready", 64'(bus.in_ready), 64'd1);

    do_op("mult",   3'd0, 32'hFFFF_FFFE, 32'h0000_0003, MUL_LAT);
    do_op("multu",  3'd1, 32'hFFFF_FFFE, 32'h0000_0003, MUL_LAT);
    do_op("div",    3'd2, 32'hFFFF_FFF9, 32'h0000_0002, DIV_LAT);
    do_op("divu",   3'd3, 32'd100,       32'd7,         DIV_LAT);
    do_op("divu0",  3'd3, 32'h1234_5678, 32'h0,         DIV_LAT);
    do_op("div0",   3'd2, 32'hFFFF_FFFB, 32'h0,         DIV_LAT);
    do_op("divovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, DIV_LAT);
    do_op("mthi",   3'd4, 32'hAAAA_5555, 32'h0,         1);

    // MFHI under back-pressure
    sb.push_back(model(3'd6, 32'h0, 32'h0));
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_op = 3'd6; bus.out_ready = 1'b0;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    @(negedge clk);
    e = sb.pop_front();
    check("mfhi valid", 64'(bus.out_valid), 64'd1);
    check("mfhi result", 64'(bus.out_result), 64'(e.res));
    held = bus.out_result;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp stable", {31'b0, bus.out_valid, bus.in_ready, held}, {31'b0, 1'b1, 1'b0, bus.out_result});
      check("bp result", 64'(bus.out_result), 64'h0000_0000_AAAA_5555);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp release", 64'(bus.out_valid), 64'd0);

    // MTLO followed back-to-back by MFLO accepted on the commit cycle
    void'(model(3'd5, 32'h0BAD_F00D, 32'h0));
    sb.push_back(model(3'd7, 32'h0, 32'h0));
    bus.in_valid = 1'b1; bus.in_op = 3'd5; bus.in_src1 = 32'h0BAD_F00D;
    @(posedge clk);
    #1 bus.in_op = 3'd7;
    @(negedge clk);
    check("b2b in_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    @(negedge clk);
    e = sb.pop_front();
    check("b2b valid", 64'(bus.out_valid), 64'd1);
    check("b2b mflo", 64'(bus.out_result), 64'(e.res));
    check("b2b lo", 64'(lo), 64'(m_lo));
    @(negedge clk);

    // Flush ten cycles into a divide
    bus.in_valid = 1'b1; bus.in_op = 3'd2; bus.in_src1 = 32'd1000; bus.in_src2 = 32'd3;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    repeat (10) @(negedge clk);
    check("flush busy_before", 64'(busy), 64'd1);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    check("flush busy", 64'(busy), 64'd0);
    any_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      any_valid |= bus.out_valid;
    end
    check("flush no_valid", 64'(any_valid), 64'd0);
    check("flush hi", 64'(hi), 64'(m_hi));
    check("flush lo", 64'(lo), 64'(m_lo));

    // Flush on the DONE && out_ready cycle suppresses commit
    bus.in_valid = 1'b1; bus.in_op = 3'd4; bus.in_src1 = 32'h1111_2222; bus.out_ready = 1'b0;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    @(negedge clk);
    check("fc valid", 64'(bus.out_valid), 64'd1);
    flush = 1'b1; bus.out_ready = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    check("fc hi", 64'(hi), 64'(m_hi));
    check("fc valid_drop", 64'(bus.out_valid), 64'd0);
    check("fc busy", 64'(busy), 64'd0);

    // Reset during MUL
    bus.in_valid = 1'b1; bus.in_op = 3'd0; bus.in_src1 = 32'd7; bus.in_src2 = 32'd9;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    @(negedge clk);
    check("rmul busy", 64'(busy), 64'd1);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rmul outs", {bus.out_valid, busy, bus.out_result}, 34'd0);
    check("rmul hi", 64'(hi), 64'd0);
    check("rmul lo", 64'(lo), 64'd0);
    m_hi = '0; m_lo = '0;
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rmul in_ready", 64'(bus.in_ready), 64'd1);
    @(negedge clk);
    check("rmul no_valid", 64'(bus.out_valid), 64'd0);

    do_op("mflo_after_rst", 3'd7, 32'h0, 32'h0, 1);
    check("sb empty", 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/exe_muldiv_unit.md
Name: exe_muldiv_unit

Overview:
- Parametrised multi-cycle multiply/divide unit for the execute stage; the successor to the single-cycle ALU path.
- Lets the execute stage hold es_ready_go low while an operation is in flight.
- Owns the architectural HI/LO registers.
- Kills in-flight work, and suppresses the HI/LO write, when a later stage raises an exception, using the same gating rule as store suppression.

Parameters:
- DATA_W, 32: operand, HI and LO width; must be even and at least 4.
- MUL_STAGES, 2: multiply latency in cycles from accept to out_valid; range 1..4.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- in_valid  in  1  operation offered by the execute stage
- in_ready  out  1  unit can accept an operation this cycle
- in_op  in  3  0=MULT 1=MULTU 2=DIV 3=DIVU 4=MTHI 5=MTLO 6=MFHI 7=MFLO
- in_src1  in  DATA_W  rs value
- in_src2  in  DATA_W  rt value
- flush  in  1  exception in the execute, memory or writeback stage; kills current and accepted ops
- out_valid  out  1  operation complete this cycle
- out_ready  in  1  downstream accepts the result (ms_allowin)
- out_result  out  DATA_W  MFHI/MFLO read value; 0 for all other ops
- busy  out  1  state is not IDLE
- hi  out  DATA_W  current HI
- lo  out  DATA_W  current LO

Behaviour:
- Reset: state IDLE; out_valid=0, out_result=0, busy=0, hi=0, lo=0; in_ready=1 one cycle after reset deasserts.
- Handshake:
  - An op is accepted on in_valid && in_ready && !flush.
  - in_ready = (state==IDLE) || (state==DONE && out_ready).
  - out_valid holds with a stable out_result until out_ready is high.
- States and transitions:
  - IDLE: accepting MULT/MULTU goes to MUL; DIV/DIVU goes to DIV; MTHI/MTLO/MFHI/MFLO go to DONE.
  - MUL: a MUL_STAGES-deep pipelined product; goes to DONE after MUL_STAGES-1 cycles, so out_valid is asserted MUL_STAGES cycles after accept.
  - DIV: restoring divider, 1 quotient bit per cycle; counter runs 0..DATA_W-1 and wraps to DONE; out_valid is asserted DATA_W+1 cycles after accept.
  - DONE: out_valid=1. On out_ready, either return to IDLE or accept a back-to-back op in the same cycle.
- Signed ops:
  - Operands are converted to magnitudes at accept.
  - Quotient is negated when the signs differ; remainder takes the dividend's sign; product sign is src1[MSB]^src2[MSB].
- Results:
  - MULT/MULTU: {hi,lo} <= 2*DATA_W-bit product.
  - DIV/DIVU: lo <= quotient, hi <= remainder.
  - MTHI/MTLO: write src1 into hi or lo.
  - MFHI/MFLO: out_result = hi or lo, sampled at accept.
- Commit: HI/LO update on the DONE && out_ready cycle only, never earlier, so a flushed op leaves no architectural trace.
- Divide by zero: no stall and no exception; quotient is all-ones and remainder equals the dividend (signed: all-ones before sign correction is not applied, quotient = all-ones).
- Signed overflow: DIV of most-negative by -1 gives lo = most-negative, hi = 0.
- Flush:
  - Any state returns to IDLE on the next edge; out_valid drops on the next edge; HI/LO are unchanged.
  - flush has priority over accept and over commit in the same cycle.
- Reset mid-operation: as flush, and also clears hi and lo.
- Pipeline back-pressure: while in DONE with out_ready=0, the divider and multiplier do not advance and in_ready=0.

Optional Feature:
- Macro MDU_RADIX4_DIV_EN.
- Defined: the divider retires 2 quotient bits per cycle; the DIV state lasts DATA_W/2 cycles; out_valid is asserted DATA_W/2+1 cycles after accept. Results are bit-identical to the radix-2 divider.
- Undefined: radix-2 only, as in Behaviour.

Test Plan:
- MULT src1=0xFFFFFFFE (-2), src2=0x00000003, out_ready=1 -> out_valid at accept+2; hi=0xFFFFFFFF, lo=0xFFFFFFFA. MULTU with the same operands -> hi=0x00000002, lo=0xFFFFFFFA.
- DIV src1=0xFFFFFFF9 (-7), src2=2 -> out_valid at accept+33 (accept+17 with MDU_RADIX4_DIV_EN); lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 100/7 -> lo=14, hi=2.
- DIVU src1=0x12345678, src2=0 -> lo=0xFFFFFFFF, hi=0x12345678. DIV 0x80000000 by 0xFFFFFFFF -> lo=0x80000000, hi=0.
- MTHI 0xAAAA5555, then MFHI -> out_result=0xAAAA5555. Hold out_ready=0 for 5 cycles -> out_valid and out_result stay stable and in_ready=0.
- Issue DIV, assert flush at cycle 10 -> busy=0 the next cycle, no out_valid, hi/lo unchanged. Assert flush in the same cycle as DONE && out_ready -> no commit.
- Assert reset during MUL -> next cycle all outputs are at reset values and in_ready=1 after reset deasserts.
